histogram_scan_reader: RTL and testbench

//  Reader for the sliding-window histogram's host read port (HisMemRD/HisMemRDAdd/HisMemRDData).
//  On Start it sweeps all DATA_NUM bins and yields statistics: mode bin/count and total count.

---
 rtl/hist_pkg.sv | 24 ++
 rtl/hist_rd_pipe.sv | 52 +++++
 rtl/histogram_scan_reader.sv | 192 +++++++++++++++++++
 tb/tb_histogram_scan_reader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared definitions for the histogram scan reader.
//   state_e         : scan FSM state encodings
//   *_DEF           : default bin-address width, bin-count width and read latency
//   result_w()      : width of the total-count result (count width + address width),
//                     wide enough that DATA_NUM full bins can never overflow it
package hist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_MED_SCAN = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int DATA_SIZE_DEF   = 4;
  localparam int LENGTH_SIZE_DEF = 6;
  localparam int RD_LAT_DEF      = 2;

  function automatic int result_w(input int length_size, input int data_size);
    return length_size + data_size;
  endfunction

endpackage

// File: rtl/hist_rd_pipe.sv
// Pending-read tracker: an RD_LAT-deep shift register of {valid, addr}.
// The output stage lines up with the cycle in which the histogram's read
// data for that address is valid.
//   clk, rstn          : clock, asynchronous active-low clear
//   in_valid, in_addr  : read strobe and address as issued this cycle
//   out_valid, out_addr: qualifier and address for the data arriving this cycle
//   drained            : no read in flight apart from the one (if any) on the output
module hist_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              drained
);

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] adr [RD_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      // NOTE: the address stages are a handful of flops, not a RAM, so they are
      // cleared too; this keeps out_addr deterministic straight after reset.
      for (int i = 0; i < RD_LAT; i++) adr[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_addr  = adr[RD_LAT-1];

  // Looking only at the stages before the output lets the FSM leave its drain
  // state in the same cycle the final return is consumed.
  always_comb begin
    drained = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (vld[i]) drained = 1'b0;
    end
  end

endmodule

// File: rtl/histogram_scan_reader.sv
// Histogram scan reader. On Start, sweeps every bin through the histogram's
// host read port while its write path is idle, streams each bin out, and
// produces mode bin/count and total count. Results hold until the next Start.
// Optional feature macro: HIST_MEDIAN_EN adds a second sweep and MedianBin.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   Start                           one-cycle scan request (ignored unless idle)
//   HisBusy                         histogram update in progress; blocks issue
//   HisMemRD, HisMemRDAdd           read strobe and bin address
//   HisMemRDData                    bin count, RD_LAT cycles after the strobe
//   Busy, Done                      scan in progress / one-cycle results-valid pulse
//   BinValid, BinAdd, BinCount      streamed bins (first sweep only)
//   ModeBin, ModeCount, TotalCount  statistics
//   MedianBin                       first bin whose running sum reaches half the total
module histogram_scan_reader
  import hist_pkg::*;
#(
  parameter int DATA_SIZE   = DATA_SIZE_DEF,
  parameter int DATA_NUM    = 2 ** DATA_SIZE,
  parameter int LENGTH_SIZE = LENGTH_SIZE_DEF,
  parameter int RD_LAT      = RD_LAT_DEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           Start,
  input  logic                           HisBusy,
  output logic                           HisMemRD,
  output logic [DATA_SIZE-1:0]           HisMemRDAdd,
  input  logic [LENGTH_SIZE-1:0]         HisMemRDData,
  output logic                           Busy,
  output logic                           Done,
  output logic                           BinValid,
  output logic [DATA_SIZE-1:0]           BinAdd,
  output logic [LENGTH_SIZE-1:0]         BinCount,
  output logic [DATA_SIZE-1:0]           ModeBin,
  output logic [LENGTH_SIZE-1:0]         ModeCount,
  output logic [LENGTH_SIZE+DATA_SIZE-1:0] TotalCount
`ifdef HIST_MEDIAN_EN
  ,
  output logic [DATA_SIZE-1:0]           MedianBin
`endif
);

  localparam int                   TOT_W    = result_w(LENGTH_SIZE, DATA_SIZE);
  localparam logic [DATA_SIZE-1:0] LAST_BIN = DATA_SIZE'(DATA_NUM - 1);

  state_e               state, state_nxt;
  logic [DATA_SIZE-1:0] issue_cnt;
  logic                 issue;
  logic                 accept;
  logic                 first_pass;
  logic                 pipe_valid;
  logic [DATA_SIZE-1:0] pipe_addr;
  logic                 drained;

`ifdef HIST_MEDIAN_EN
  logic             issue_last;   // second sweep has issued its final bin
  logic             med_found;
  logic [TOT_W-1:0] cum_sum, cum_next, med_thr;

  assign cum_next = cum_sum + TOT_W'(HisMemRDData);
  assign med_thr  = (TotalCount + TOT_W'(1)) >> 1;
`endif

  assign accept     = (state == ST_IDLE) && Start;
  assign first_pass = (state == ST_SCAN) || (state == ST_DRAIN);

  // NOTE: every signal this block drives gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE:  if (Start) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (!HisBusy) begin
          issue = 1'b1;
          if (issue_cnt == LAST_BIN) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drained) begin
`ifdef HIST_MEDIAN_EN
          state_nxt = ST_MED_SCAN;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef HIST_MEDIAN_EN
      ST_MED_SCAN: begin
        if (!issue_last && !HisBusy) issue = 1'b1;
        if (issue_last && drained) state_nxt = ST_DONE;
      end
`endif
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign HisMemRD    = issue;
  assign HisMemRDAdd = issue_cnt;
  assign Busy        = (state != ST_IDLE);
  assign Done        = (state == ST_DONE);

  // NOTE: all clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  hist_rd_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (DATA_SIZE)
  ) u_rd_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (issue),
    .in_addr   (issue_cnt),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .drained   (drained)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt  <= '0;
      BinValid   <= 1'b0;
      BinAdd     <= '0;
      BinCount   <= '0;
      ModeBin    <= '0;
      ModeCount  <= '0;
      TotalCount <= '0;
`ifdef HIST_MEDIAN_EN
      issue_last <= 1'b0;
      med_found  <= 1'b0;
      cum_sum    <= '0;
      MedianBin  <= '0;
`endif
    end else begin
      BinValid <= 1'b0;

      if (accept) begin
        issue_cnt  <= '0;
        ModeBin    <= '0;
        ModeCount  <= '0;
        TotalCount <= '0;
`ifdef HIST_MEDIAN_EN
        issue_last <= 1'b0;
        med_found  <= 1'b0;
        cum_sum    <= '0;
        MedianBin  <= '0;
`endif
      end

      // The counter parks on the last bin instead of wrapping back to 0.
      if (issue && (issue_cnt != LAST_BIN)) issue_cnt <= issue_cnt + 1'b1;

`ifdef HIST_MEDIAN_EN
      if (issue && (issue_cnt == LAST_BIN) && (state == ST_MED_SCAN)) issue_last <= 1'b1;
      if ((state == ST_DRAIN) && drained) begin
        issue_cnt  <= '0;
        issue_last <= 1'b0;
      end
`endif

      if (pipe_valid && first_pass) begin
        BinValid   <= 1'b1;
        BinAdd     <= pipe_addr;
        BinCount   <= HisMemRDData;
        TotalCount <= TotalCount + TOT_W'(HisMemRDData);
        // Strict compare: on a tie the lower-numbered bin seen first is kept.
        if (HisMemRDData > ModeCount) begin
          ModeBin   <= pipe_addr;
          ModeCount <= HisMemRDData;
        end
      end

`ifdef HIST_MEDIAN_EN
      if (pipe_valid && (state == ST_MED_SCAN)) begin
        cum_sum <= cum_next;
        if (!med_found && (cum_next >= med_thr)) begin
          med_found <= 1'b1;
          MedianBin <= pipe_addr;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_histogram_scan_reader.sv
// Self-checking bench for histogram_scan_reader. A behavioural histogram
// memory answers reads RD_LAT cycles later; expected bins are queued when a
// scan is started and popped as the DUT streams them out.
module tb_histogram_scan_reader;

  localparam int DS = 4;
  localparam int LS = 6;
  localparam int DN = 16;
  localparam int TW = LS + DS;

  typedef struct {
    logic [DS-1:0] addr;
    logic [LS-1:0] count;
  } bin_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          Start;
  logic          HisBusy;
  logic          HisMemRD;
  logic [DS-1:0] HisMemRDAdd;
  logic [LS-1:0] HisMemRDData;
  logic          Busy;
  logic          Done;
  logic          BinValid;
  logic [DS-1:0] BinAdd;
  logic [LS-1:0] BinCount;
  logic [DS-1:0] ModeBin;
  logic [LS-1:0] ModeCount;
  logic [TW-1:0] TotalCount;
`ifdef HIST_MEDIAN_EN
  logic [DS-1:0] MedianBin;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  histogram_scan_reader dut (
    .clk          (clk),
    .rstn         (rstn),
    .Start        (Start),
    .HisBusy      (HisBusy),
    .HisMemRD     (HisMemRD),
    .HisMemRDAdd  (HisMemRDAdd),
    .HisMemRDData (HisMemRDData),
    .Busy         (Busy),
    .Done         (Done),
    .BinValid     (BinValid),
    .BinAdd       (BinAdd),
    .BinCount     (BinCount),
    .ModeBin      (ModeBin),
    .ModeCount    (ModeCount),
    .TotalCount   (TotalCount)
`ifdef HIST_MEDIAN_EN
    ,
    .MedianBin    (MedianBin)
`endif
  );

  // Histogram memory model: two-stage read latency; garbage when no read is due.
  logic [LS-1:0] mem [DN];
  logic [DS-1:0] a1, a2;
  logic          r1, r2;
  always @(posedge clk) begin
    r1 <= HisMemRD;
    a1 <= HisMemRDAdd;
    r2 <= r1;
    a2 <= a1;
  end
  assign HisMemRDData = r2 ? mem[a2] : 6'h2A;

  task automatic test_reset();
    rstn = 1'b0; Start = 1'b0; HisBusy = 1'b0;
    for (int i = 0; i < DN; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({Busy, Done, HisMemRD, BinValid} !== 4'b0)
      $display("FAIL reset_ctrl got %b want 0000", {Busy, Done, HisMemRD, BinValid});
    else n_pass++;
    n_total++;
    if ({ModeBin, ModeCount, TotalCount} !== '0)
      $display("FAIL reset_results got %h/%h/%h want 0", ModeBin, ModeCount, TotalCount);
    else n_pass++;
    n_total++;
    if ({HisMemRDAdd, BinAdd, BinCount} !== '0)
      $display("FAIL reset_addr got %h/%h/%h want 0", HisMemRDAdd, BinAdd, BinCount);
    else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
    n_total++;
    if (Busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", Busy);
    else n_pass++;
  endtask

  // Runs one complete scan of the current mem[] contents and checks it.
  task automatic run_scan(input string name, input bit toggle_busy,
                          input int start_mid, input int exp_done);
    bin_t sb[$];
    bin_t e;
    int exp_mode_bin = 0, exp_mode_cnt = 0, exp_total = 0;
    int exp_med = 0, cum = 0, thr;
    bit found = 0;
    int rd_cnt = 0, addr_err = 0, overlap = 0, extra = 0;
    int first_rd = -1, last_rd = -1, done_cnt = 0, done_cyc = -1, cyc;

    for (int i = 0; i < DN; i++) begin
      sb.push_back('{addr: DS'(i), count: mem[i]});
      exp_total += int'(mem[i]);
      if (int'(mem[i]) > exp_mode_cnt) begin
        exp_mode_cnt = int'(mem[i]);
        exp_mode_bin = i;
      end
    end
    thr = (exp_total + 1) / 2;
    for (int i = 0; i < DN; i++) begin
      cum += int'(mem[i]);
      if (!found && cum >= thr) begin
        found = 1;
        exp_med = i;
      end
    end

    @(negedge clk);
    Start = 1'b1; HisBusy = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    cyc = 1;
    n_total++;
    if (Busy !== 1'b1) $display("FAIL %s busy_after_start got %b want 1", name, Busy);
    else n_pass++;

    for (int k = 0; k < 300; k++) begin
      if (HisMemRD && HisBusy) overlap++;
      if (HisMemRD) begin
        if (HisMemRDAdd !== DS'(rd_cnt)) addr_err++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        rd_cnt++;
      end
      if (BinValid) begin
        if (sb.size() == 0) extra++;
        else begin
          e = sb.pop_front();
          n_total++;
          if ({BinAdd, BinCount} !== {e.addr, e.count})
            $display("FAIL %s bin got %0d:%0d want %0d:%0d", name, BinAdd, BinCount, e.addr, e.count);
          else n_pass++;
        end
      end
      if (Done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      Start = (start_mid != 0) && (cyc == start_mid);
      if (toggle_busy) HisBusy = (cyc % 2 == 1);
      @(negedge clk);
      cyc++;
    end
    Start = 1'b0; HisBusy = 1'b0;

    n_total++;
    if (rd_cnt != DN) $display("FAIL %s rd_count got %0d want %0d", name, rd_cnt, DN);
    else n_pass++;
    n_total++;
    if (addr_err != 0 || overlap != 0)
      $display("FAIL %s issue got addr_err=%0d overlap=%0d want 0/0", name, addr_err, overlap);
    else n_pass++;
    n_total++;
    if (sb.size() != 0 || extra != 0)
      $display("FAIL %s stream got left=%0d extra=%0d want 0/0", name, sb.size(), extra);
    else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL %s done_pulses got %0d want 1", name, done_cnt);
    else n_pass++;
    n_total++;
    if (ModeBin !== DS'(exp_mode_bin) || ModeCount !== LS'(exp_mode_cnt))
      $display("FAIL %s mode got %0d/%0d want %0d/%0d", name, ModeBin, ModeCount, exp_mode_bin, exp_mode_cnt);
    else n_pass++;
    n_total++;
    if (TotalCount !== TW'(exp_total))
      $display("FAIL %s total got %0d want %0d", name, TotalCount, exp_total);
    else n_pass++;
    n_total++;
    if (Busy !== 1'b0) $display("FAIL %s idle_after got busy=%b want 0", name, Busy);
    else n_pass++;
    if (exp_done > 0) begin
      n_total++;
      if (done_cyc != exp_done) $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_done);
      else n_pass++;
    end
    if (!toggle_busy) begin
      n_total++;
      if (first_rd != 1 || last_rd != DN)
        $display("FAIL %s rd_window got %0d..%0d want 1..%0d", name, first_rd, last_rd, DN);
      else n_pass++;
    end
`ifdef HIST_MEDIAN_EN
    n_total++;
    if (MedianBin !== DS'(exp_med)) $display("FAIL %s median got %0d want %0d", name, MedianBin, exp_med);
    else n_pass++;
`else
    if (exp_med < 0) $display("unexpected median model value");
`endif
  endtask

  task automatic test_ramp();
    for (int i = 0; i < DN; i++) mem[i] = LS'(i);
`ifdef HIST_MEDIAN_EN
    run_scan("ramp", 0, 0, -1);
`else
    run_scan("ramp", 0, 0, DN + 2 + 1);
`endif
  endtask

  task automatic test_tie();
    for (int i = 0; i < DN; i++) mem[i] = 6'd1;
    mem[3] = 6'd7;
    mem[9] = 6'd7;
    run_scan("tie", 0, 0, -1);
  endtask

  task automatic test_busy_stall();
    for (int i = 0; i < DN; i++) mem[i] = LS'(i);
    run_scan("busy_toggle", 1, 0, -1);
  endtask

  task automatic test_empty();
    for (int i = 0; i < DN; i++) mem[i] = '0;
`ifdef HIST_MEDIAN_EN
    run_scan("empty", 0, 0, -1);
`else
    run_scan("empty", 0, 0, DN + 2 + 1);
`endif
  endtask

  task automatic test_start_ignored_and_reset();
    int stray = 0;
    for (int i = 0; i < DN; i++) mem[i] = LS'(DN - i);
`ifdef HIST_MEDIAN_EN
    run_scan("start_ignored", 0, 5, -1);
`else
    run_scan("start_ignored", 0, 5, DN + 2 + 1);
`endif
    for (int i = 0; i < DN; i++) mem[i] = LS'(i + 1);
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (8) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_total++;
    if ({Busy, Done, HisMemRD, BinValid} !== 4'b0)
      $display("FAIL midreset_ctrl got %b want 0000", {Busy, Done, HisMemRD, BinValid});
    else n_pass++;
    n_total++;
    if ({ModeBin, ModeCount, TotalCount, BinAdd, BinCount} !== '0)
      $display("FAIL midreset_results got %h/%h/%h want 0", ModeBin, ModeCount, TotalCount);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (BinValid || Busy || HisMemRD) stray++;
    end
    n_total++;
    if (stray != 0) $display("FAIL midreset_discard got %0d stray cycles want 0", stray);
    else n_pass++;
    for (int i = 0; i < DN; i++) mem[i] = LS'((i * 5) % 13);
    run_scan("after_reset", 0, 0, -1);
  endtask

`ifdef HIST_MEDIAN_EN
  task automatic test_median();
    for (int i = 0; i < DN; i++) mem[i] = '0;
    mem[2]  = 6'd11;
    mem[5]  = 6'd5;
    mem[12] = 6'd5;
    run_scan("median_a", 0, 0, -1);
    mem[2] = 6'd5;
    run_scan("median_b", 0, 0, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_tie();
    test_busy_stall();
    test_empty();
    test_start_ignored_and_reset();
`ifdef HIST_MEDIAN_EN
    test_median();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
